// File: rtl/audio_frame_path.sv
// Frame sequencer for the ADC/DAC serial engines: tick/start timing, round-robin
// channel capture, saturating gain, output mode and ADC-to-DAC width conversion.
module audio_frame_path #(
    parameter int unsigned CLK_DIV   = 32,
    parameter int unsigned FRAME_LEN = 21,
    parameter int unsigned ADC_BITS  = 10,
    parameter int unsigned DAC_BITS  = 12,
    parameter int unsigned NUM_CH    = 1,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [1:0]          gain_shift,
    input  logic [ADC_BITS-1:0] adc_data,
    output logic                tick,
    output logic                start,
    output logic [CH_W-1:0]     adc_ch,
    output logic [ADC_BITS-1:0] sample_out,
    output logic [CH_W-1:0]     sample_ch,
    output logic                sample_valid,
    output logic [DAC_BITS-1:0] dac_data,
    output logic [CH_W-1:0]     dac_ch
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned SW = $clog2(FRAME_LEN);
    localparam int unsigned GW = ADC_BITS + 3;

    localparam logic [PW-1:0]       PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0]       SLOT_LAST = SW'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0]     CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [GW-1:0]       MID_G     = GW'(1) << (ADC_BITS - 1);
    localparam logic [GW-1:0]       MAX_G     = MID_G - GW'(1);
    localparam logic [DAC_BITS-1:0] DAC_MID   = DAC_BITS'(1) << (DAC_BITS - 1);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_MUTE = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;
    localparam logic [1:0] MODE_RAMP = 2'b11;

    logic [PW-1:0]       prescaler;
    logic [SW-1:0]       slot;
    logic [1:0]          mode_q;
    logic [1:0]          gain_q;
    logic [DAC_BITS-1:0] ramp;
    logic                capture_c;

    logic signed [GW-1:0] diff_c;
    logic signed [GW-1:0] gained_c;
    logic signed [GW-1:0] sat_c;
    logic [ADC_BITS-1:0]  proc_c;
    logic [DAC_BITS-1:0]  conv_c;

    assign tick      = enable && (prescaler == PRE_LAST);
    assign start     = tick && (slot == '0);
    assign capture_c = tick && (slot == SLOT_LAST);

    // Gain about midscale with saturation to the ADC range
    always_comb begin
        diff_c   = $signed(GW'(sample_out) - MID_G);
        gained_c = diff_c <<< gain_q;
        sat_c    = gained_c;
        if (gained_c > $signed(MAX_G)) begin
            sat_c = $signed(MAX_G);
        end else if (gained_c < -$signed(MID_G)) begin
            sat_c = -$signed(MID_G);
        end
        proc_c = ADC_BITS'($unsigned(sat_c) + MID_G);
    end

    if (DAC_BITS >= ADC_BITS) begin : g_widen
        assign conv_c = DAC_BITS'(proc_c) << (DAC_BITS - ADC_BITS);
    end else begin : g_narrow
        assign conv_c = proc_c[ADC_BITS-1 -: DAC_BITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            slot         <= '0;
            adc_ch       <= '0;
            sample_out   <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            dac_data     <= DAC_MID;
            dac_ch       <= '0;
            mode_q       <= MODE_PASS;
            gain_q       <= '0;
            ramp         <= '0;
        end else begin
            sample_valid <= capture_c;

            // Dropping enable discards the partial frame
            if (!enable) begin
                prescaler <= '0;
                slot      <= '0;
            end else if (tick) begin
                prescaler <= '0;
                slot      <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            // Mode and gain are frozen with the sample so mid-frame changes wait
            if (capture_c) begin
                sample_out <= adc_data;
                sample_ch  <= adc_ch;
                adc_ch     <= (adc_ch == CH_LAST) ? '0 : adc_ch + CH_W'(1);
                mode_q     <= mode;
                gain_q     <= gain_shift;
            end

            if (sample_valid) begin
                case (mode_q)
                    MODE_PASS: begin
                        dac_data <= conv_c;
                        dac_ch   <= sample_ch;
                    end
                    MODE_MUTE: begin
                        dac_data <= DAC_MID;
                        dac_ch   <= sample_ch;
                    end
                    MODE_RAMP: begin
                        dac_data <= ramp;
                        dac_ch   <= sample_ch;
                        ramp     <= ramp + DAC_BITS'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
